// File: rtl/divisor_restauracion_if.sv
// Purpose: bundles the request/result signals of the restoring divider.
// Ports:   start, dividendo, divisor (requester -> divider);
//          cociente, resto, ocupado, fin, div_cero (divider -> requester).
interface divisor_restauracion_if #(
    parameter int N = 4
);
    logic         start;
    logic [N-1:0] dividendo;
    logic [N-1:0] divisor;
    logic [N-1:0] cociente;
    logic [N-1:0] resto;
    logic         ocupado;
    logic         fin;
    logic         div_cero;

    // Requester side: issues operands, observes results.
    modport master (
        output start, dividendo, divisor,
        input  cociente, resto, ocupado, fin, div_cero
    );

    // Divider side.
    modport slave (
        input  start, dividendo, divisor,
        output cociente, resto, ocupado, fin, div_cero
    );
endinterface

// File: rtl/divisor_restauracion.sv
// Purpose: N-bit unsigned restoring divider, one shift cycle and one subtract
//          cycle per quotient bit (fin 2N cycles after the accepting edge).
// Ports:   clk, reset (async, active-high), bus (slave side of
//          divisor_restauracion_if: start/dividendo/divisor in,
//          cociente/resto/ocupado/fin/div_cero out).
// Option:  define DIVISOR_CERO_EN to short-circuit divide-by-zero straight to
//          FIN with div_cero raised; otherwise div_cero is tied low and a zero
//          divisor runs the normal iteration (quotient all ones, rest = dividend).
module divisor_restauracion #(
    parameter int N = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    divisor_restauracion_if.slave  bus
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        REPOSO   = 2'd0,
        DESPLAZA = 2'd1,
        RESTA    = 2'd2,
        FIN      = 2'd3
    } estado_t;

    estado_t       estado;
    estado_t       estado_sig;
    logic [N:0]    a;       // signed partial remainder, one guard bit
    logic [N-1:0]  q;
    logic [N-1:0]  m;
    logic [CW-1:0] cuenta;
    logic [N:0]    t;
    logic          acepta;
    logic          es_cero;

    assign acepta  = (estado == REPOSO) && bus.start;
    assign t       = a - {1'b0, m};

`ifdef DIVISOR_CERO_EN
    assign es_cero = (bus.divisor == '0);
`else
    assign es_cero = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado <= REPOSO;
        end else begin
            estado <= estado_sig;
        end
    end

    // Next-state logic
    always_comb begin
        estado_sig = estado;
        case (estado)
            REPOSO:   if (acepta) estado_sig = es_cero ? FIN : DESPLAZA;
            DESPLAZA: estado_sig = RESTA;
            // The counter was already decremented in DESPLAZA, so zero here
            // means the last quotient bit has just been resolved.
            RESTA:    estado_sig = (cuenta != '0) ? DESPLAZA : FIN;
            FIN:      estado_sig = REPOSO;
            default:  estado_sig = REPOSO;
        endcase
    end

    // Output logic
    always_comb begin
        bus.ocupado = 1'b0;
        bus.fin     = 1'b0;
        case (estado)
            DESPLAZA: bus.ocupado = 1'b1;
            RESTA:    bus.ocupado = 1'b1;
            FIN:      bus.fin     = 1'b1;
            default:  ;
        endcase
    end

    // Datapath: registers only move on the accepting edge and while iterating,
    // so results stay put through FIN and the following idle cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a      <= '0;
            q      <= '0;
            m      <= '0;
            cuenta <= '0;
        end else begin
            case (estado)
                REPOSO: begin
                    if (acepta) begin
                        m <= bus.divisor;
                        if (es_cero) begin
                            a      <= {1'b0, bus.dividendo};
                            q      <= '1;
                            cuenta <= '0;
                        end else begin
                            a      <= '0;
                            q      <= bus.dividendo;
                            cuenta <= CW'(N);
                        end
                    end
                end
                DESPLAZA: begin
                    a      <= {a[N-1:0], q[N-1]};
                    q      <= {q[N-2:0], 1'b0};
                    cuenta <= cuenta - CW'(1);
                end
                RESTA: begin
                    // Keep the difference only when it did not go negative;
                    // otherwise A is left untouched (the "restore").
                    if (!t[N]) begin
                        a <= t;
                        q <= {q[N-1:1], 1'b1};
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef DIVISOR_CERO_EN
    logic div_cero_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cero_q <= 1'b0;
        end else if (acepta) begin
            div_cero_q <= es_cero;
        end
    end

    assign bus.div_cero = div_cero_q;
`else
    assign bus.div_cero = 1'b0;
`endif

    assign bus.cociente = q;
    assign bus.resto    = a[N-1:0];

endmodule

// File: tb/tb_divisor_restauracion.sv
// Purpose: directed self-checking bench for divisor_restauracion (N=4).
// Ports:   none; drives the divider through divisor_restauracion_if.
// Build with or without DIVISOR_CERO_EN; the divide-by-zero vector adapts.
module tb_divisor_restauracion;
    localparam int N = 4;

    logic clk;
    logic reset;
    int   n_total;
    int   n_pass;
    int   cyc;

    divisor_restauracion_if #(.N(N)) bus ();

    divisor_restauracion #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one division from REPOSO and follows it to FIN and back.
    // lat is counted in edges after the accepting edge.
    task automatic run_div(input string tag, input int dd, input int dv,
                           input int lat_exp, input int ocup_exp,
                           input int q_exp, input int r_exp, input int dz_exp);
        int lat;
        int ocup;
        bit got;
        bus.dividendo = N'(dd);
        bus.divisor   = N'(dv);
        bus.start     = 1'b1;
        tick();
        bus.start = 1'b0;
        lat  = 0;
        ocup = 0;
        got  = 1'b0;
        if (bus.fin) got = 1'b1;
        else if (bus.ocupado) ocup++;
        while (!got && lat < 30) begin
            tick();
            lat++;
            if (bus.fin) got = 1'b1;
            else if (bus.ocupado) ocup++;
        end
        check({tag, "_lat"},  lat, lat_exp);
        check({tag, "_ocup"}, ocup, ocup_exp);
        check({tag, "_q"},    int'(bus.cociente), q_exp);
        check({tag, "_r"},    int'(bus.resto), r_exp);
        check({tag, "_dz"},   int'(bus.div_cero), dz_exp);
        tick();
        check({tag, "_fin_drop"}, int'(bus.fin), 0);
        check({tag, "_q_hold"},   int'(bus.cociente), q_exp);
    endtask

    initial begin
        int fins;
        int q_seen;
        int r_seen;
        int last;
        int na;
        int nb;

        n_total = 0;
        n_pass  = 0;
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.dividendo = '0;
        bus.divisor   = '0;

        // Reset state
        tick();
        check("rst_q",    int'(bus.cociente), 0);
        check("rst_r",    int'(bus.resto), 0);
        check("rst_ocup", int'(bus.ocupado), 0);
        check("rst_fin",  int'(bus.fin), 0);
        check("rst_dz",   int'(bus.div_cero), 0);
        tick();
        reset = 1'b0;
        tick();

        // Basic vectors
        run_div("d13_4", 13, 4, 8, 8, 3, 1, 0);
        run_div("d15_1", 15, 1, 8, 8, 15, 0, 0);
        run_div("d5_7",  5, 7, 8, 8, 0, 5, 0);
        run_div("d0_3",  0, 3, 8, 8, 0, 0, 0);
`ifdef DIVISOR_CERO_EN
        run_div("d9_0",  9, 0, 0, 0, 15, 9, 1);
`else
        run_div("d9_0",  9, 0, 8, 8, 15, 9, 0);
`endif
        // div_cero must drop on the next accepted division
        run_div("d7_2",  7, 2, 8, 8, 3, 1, 0);

        // start and operand changes mid-division are ignored
        bus.dividendo = 4'd13;
        bus.divisor   = 4'd4;
        bus.start     = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (3) tick();
        bus.start     = 1'b1;
        bus.dividendo = 4'd6;
        bus.divisor   = 4'd2;
        tick();
        bus.start = 1'b0;
        fins   = 0;
        q_seen = -1;
        r_seen = -1;
        for (int i = 0; i < 15; i++) begin
            if (bus.fin) begin
                fins++;
                q_seen = int'(bus.cociente);
                r_seen = int'(bus.resto);
            end
            tick();
        end
        check("ign_fins", fins, 1);
        check("ign_q", q_seen, 3);
        check("ign_r", r_seen, 1);

        // Reset mid-division
        bus.dividendo = 4'd14;
        bus.divisor   = 4'd3;
        bus.start     = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        #1;
        check("mrst_q",    int'(bus.cociente), 0);
        check("mrst_r",    int'(bus.resto), 0);
        check("mrst_ocup", int'(bus.ocupado), 0);
        check("mrst_fin",  int'(bus.fin), 0);
        check("mrst_dz",   int'(bus.div_cero), 0);
        fins = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.fin) fins++;
        end
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.fin) fins++;
        end
        check("mrst_nofin", fins, 0);
        run_div("d14_3", 14, 3, 8, 8, 4, 2, 0);

        // Exhaustive sweep with start held high
        last          = -1;
        bus.dividendo = 4'd0;
        bus.divisor   = 4'd1;
        bus.start     = 1'b1;
        for (int a = 0; a < 16; a++) begin
            for (int b = 1; b < 16; b++) begin
                int w;
                w = 0;
                while (!bus.fin && w < 30) begin
                    tick();
                    w++;
                end
                check("sw_fin_seen", int'(bus.fin), 1);
                check("sw_eq", int'(bus.cociente) * b + int'(bus.resto), a);
                check("sw_rlt", int'(int'(bus.resto) < b), 1);
                check("sw_q", int'(bus.cociente), a / b);
                if (last >= 0) check("sw_period", cyc - last, 10);
                last = cyc;
                if (b == 15) begin
                    na = a + 1;
                    nb = 1;
                end else begin
                    na = a;
                    nb = b + 1;
                end
                bus.dividendo = N'(na);
                bus.divisor   = N'(nb);
                if (na == 16) bus.start = 1'b0;
                tick();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/divisor_restauracion.md
DIVISOR_RESTAURACION -- requirements
Module: divisor_restauracion

Interface
REQ-001 Parameter N, default 4, operand width in bits; legal range 2..16.
REQ-002 clk  input  1  clock; all state changes on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to begin a division; sampled only in state REPOSO.
REQ-005 dividendo  input  N  unsigned dividend; captured on the accepting edge.
REQ-006 divisor  input  N  unsigned divisor; captured on the accepting edge.
REQ-007 cociente  output  N  quotient, taken directly from register Q.
REQ-008 resto  output  N  remainder, taken directly from A[N-1:0].
REQ-009 ocupado  output  1  high in states DESPLAZA and RESTA.
REQ-010 fin  output  1  high for exactly one cycle, in state FIN.
REQ-011 div_cero  output  1  divide-by-zero flag (see Configuration).

Function
REQ-012 The block SHALL use these registers: A (N+1 bits, signed partial remainder), Q (N bits), M (N bits), iteration counter (ceil(log2(N+1)) bits), and a 2-bit state register.
REQ-013 States SHALL be REPOSO, DESPLAZA, RESTA and FIN.
REQ-014 In REPOSO with start=1, the edge SHALL load A=0, Q=dividendo, M=divisor and counter=N, and move to DESPLAZA.
REQ-015 DESPLAZA edge SHALL shift {A,Q} left one bit, clear Q[0], decrement the counter and move to RESTA.
REQ-016 RESTA SHALL compute T = A - {0,M} in N+1 bits.
REQ-017 In RESTA, if T[N]=0 then A=T and Q[0]=1; otherwise A is unchanged (restore) and Q[0] stays 0.
REQ-018 From RESTA the next state SHALL be DESPLAZA if counter≠0, else FIN.
REQ-019 Latency: fin SHALL be high in the cycle after the 2N-th edge following the accepting edge; FIN SHALL return to REPOSO on the next edge.
REQ-020 cociente and resto SHALL hold their final values from FIN until the next accepting edge.
REQ-021 start SHALL be ignored in DESPLAZA, RESTA and FIN; no restart and no input recapture.
REQ-022 Input changes on dividendo or divisor after the accepting edge SHALL have no effect on the result.
REQ-023 Results SHALL satisfy dividendo = cociente*divisor + resto, with resto < divisor, for every divisor≠0.
REQ-024 start held high continuously SHALL produce back-to-back divisions, each accepted in the REPOSO cycle that follows FIN.

Reset
REQ-025 reset=1 SHALL force the following immediately, regardless of clk: state=REPOSO, A=0, Q=0, M=0, counter=0.
REQ-026 The forced values of REQ-025 SHALL make cociente=0, resto=0, ocupado=0, fin=0 and div_cero=0.
REQ-027 Reset mid-operation SHALL abandon the division with no fin pulse.
REQ-028 The first division SHALL be accepted on the first edge with start=1 after reset deasserts.

Configuration
REQ-029 Macro DIVISOR_CERO_EN SHALL control divide-by-zero detection.
REQ-030 With DIVISOR_CERO_EN defined, an accepting edge with divisor=0 SHALL load Q=all ones and A={0,dividendo}, set div_cero=1 and go directly to FIN, so fin is high in the following cycle.
REQ-031 With DIVISOR_CERO_EN defined, div_cero SHALL hold until the next accepting edge or reset.
REQ-032 Without DIVISOR_CERO_EN, divisor=0 SHALL run the normal 2N-cycle iteration, yielding cociente=all ones and resto=dividendo, and div_cero SHALL be tied to 0.

Verification
REQ-033 N=4, dividendo=13, divisor=4, start pulse -> fin 8 cycles after the accepting edge, cociente=3, resto=1, ocupado high for exactly 8 cycles.
REQ-034 N=4: 15/1 -> cociente=15, resto=0; 5/7 -> cociente=0, resto=5; 0/3 -> cociente=0, resto=0.
REQ-035 N=4, 9/0 -> with macro: fin 1 cycle after acceptance, cociente=15, resto=9, div_cero=1; without macro: fin at 8 cycles, cociente=15, resto=9, div_cero=0.
REQ-036 Start 13/4, then pulse start with 6/2 during cycle 3 -> result stays 3 r 1 and exactly one fin pulse occurs.
REQ-037 Start 14/3, assert reset in cycle 4 -> all outputs 0 at once, no fin; after release, 14/3 -> cociente=4, resto=2.
REQ-038 Exhaustive N=4 sweep of dividendo 0..15 x divisor 1..15 with start held high -> REQ-023 holds for every pair, and consecutive fin pulses are 10 cycles apart.
